// File: rtl/lcd_frame_scanner_if.sv
// Pixel capture input and panel scan output bundle
// for lcd_frame_scanner.
interface lcd_frame_scanner_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic [7:0] lcd_data;
  logic       lcd_de;
  logic       lcd_hs;
  logic       lcd_vs;
  logic       lcd_frame_start;
  logic       drop_err;
  logic       overrun;

  modport master (
    output pix_in, pix_valid,
    input  lcd_data, lcd_de, lcd_hs, lcd_vs,
    input  lcd_frame_start, drop_err, overrun
  );

  modport slave (
    input  pix_in, pix_valid,
    output lcd_data, lcd_de, lcd_hs, lcd_vs,
    output lcd_frame_start, drop_err, overrun
  );
endinterface

// File: rtl/lcd_frame_scanner.sv
// Double-buffered 4x4 frame store: captures 16-pixel bursts
// and rescans the latest complete frame as vs/hs/de panel timing.
module lcd_frame_scanner #(
  parameter int V_BLANK = 3,
  parameter int H_BLANK = 2,
  parameter int PIX_DIV = 1
) (
  input logic           clk,
  input logic           reset,
  lcd_frame_scanner_if.slave bus
);

  localparam int M1 = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
  localparam int MX = (M1 > PIX_DIV) ? M1 : PIX_DIV;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] V_LAST = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] D_LAST = CW'(PIX_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VSYNC,
    S_HBLANK,
    S_ACTIVE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [4:0]      wcnt_q, wcnt_d;
  logic            pend_q, pend_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [7:0]      data_q, data_d;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            fs_q, fs_d;
  logic            drop_q, drop_d;
  logic            ovr_q, ovr_d;
  logic            complete;
  logic            take;
  logic            swap;
  logic            we;

  logic [7:0]      mem_q [2][16];

  assign complete = bus.pix_valid && (wcnt_q == 5'd15);
  assign take     = pend_q | complete;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    swap    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          swap    = 1'b1;
          state_d = S_VSYNC;
          cnt_d   = '0;
        end
      end
      S_VSYNC: begin
        if (cnt_q == V_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
          row_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HBLANK: begin
        if (cnt_q == H_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          col_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (cnt_q == D_LAST) begin
          cnt_d = '0;
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) begin
            if (row_q == 2'd3) begin
              // frame end: a frame completing right now is taken too
              state_d = S_VSYNC;
              swap    = take;
            end else begin
              state_d = S_HBLANK;
              row_d   = row_q + 2'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wcnt_d  = wcnt_q;
    pend_d  = pend_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    drop_d  = 1'b0;
    ovr_d   = 1'b0;
    we      = 1'b0;
    if (bus.pix_valid) begin
      we     = 1'b1;
      wcnt_d = complete ? 5'd0 : wcnt_q + 5'd1;
    end else if (wcnt_q != 5'd0) begin
      drop_d = 1'b1;
      wcnt_d = 5'd0;
    end
    if (complete && !swap) begin
      pend_d = 1'b1;
      ovr_d  = pend_q;
    end
    if (swap) begin
      pend_d  = 1'b0;
      wbank_d = ~wbank_q;
      rbank_d = ~rbank_q;
    end
  end

  always_comb begin
    vs_d   = (state_q == S_VSYNC);
    fs_d   = (state_q == S_VSYNC) && (cnt_q == '0);
    hs_d   = (state_q == S_HBLANK);
    de_d   = (state_q == S_ACTIVE);
    data_d = 8'd0;
    if (state_q == S_ACTIVE) begin
      data_d = mem_q[rbank_q][{row_q, col_q}];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wbank_q][wcnt_q[3:0]] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      wcnt_q  <= 5'd0;
      pend_q  <= 1'b0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b1;
      data_q  <= 8'd0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      drop_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      data_q  <= data_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      drop_q  <= drop_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.lcd_data        = data_q;
  assign bus.lcd_de          = de_q;
  assign bus.lcd_hs          = hs_q;
  assign bus.lcd_vs          = vs_q;
  assign bus.lcd_frame_start = fs_q;
  assign bus.drop_err        = drop_q;
  assign bus.overrun         = ovr_q;

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Bench for lcd_frame_scanner: frame-position reference model,
// burst table, hand-built corner sequences, random bursts.
module tb_lcd_frame_scanner;

  localparam int VB  = 3;
  localparam int HB  = 2;
  localparam int PD  = 1;
  localparam int RL  = HB + 4 * PD;
  localparam int PER = VB + 4 * RL;

  typedef struct {
    int         len;
    logic [7:0] base;
    int         drops;
    int         ovrs;
    logic [7:0] show;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_frame_scanner_if bus_a ();
  lcd_frame_scanner_if bus_b ();

  lcd_frame_scanner u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  lcd_frame_scanner #(
    .V_BLANK (1),
    .H_BLANK (1),
    .PIX_DIV (2)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_bank [2][16];
  int         m_wb, m_rb, m_wcnt, m_t;
  bit         m_pend, m_scan;
  logic [7:0] e_data;
  bit         e_de, e_hs, e_vs, e_fs, e_drop, e_ovr;

  // observation
  int         cyc = 0;
  int         last_fs = 0;
  int         n_drop, n_ovr, saw_a;
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  int         fsb [$];

  vec_t tbl [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_wb   = 0;
    m_rb   = 1;
    m_wcnt = 0;
    m_t    = 0;
    m_pend = 0;
    m_scan = 0;
  endtask

  // One clock edge of the spec's behaviour, expressed as a position
  // within the frame period rather than a state machine.
  task automatic model_edge();
    bit v, comp, take, swp;
    logic [7:0] p;
    int r, o;
    v    = bus_a.pix_valid;
    p    = bus_a.pix_in;
    comp = v && (m_wcnt == 15);
    take = m_pend || comp;
    swp  = 0;
    e_data = 8'd0;
    e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0;
    if (m_scan) begin
      if (m_t < VB) begin
        e_vs = 1;
        e_fs = (m_t == 0);
      end else begin
        r = (m_t - VB) / RL;
        o = (m_t - VB) % RL;
        if (o < HB) e_hs = 1;
        else begin
          e_de   = 1;
          e_data = m_bank[m_rb][r * 4 + (o - HB) / PD];
        end
      end
      if (m_t == PER - 1) begin
        m_t = 0;
        swp = take;
      end else m_t++;
    end else if (take) begin
      m_scan = 1;
      m_t    = 0;
      swp    = 1;
    end
    e_drop = !v && (m_wcnt != 0);
    e_ovr  = comp && m_pend && !swp;
    if (v) begin
      m_bank[m_wb][m_wcnt] = p;
      m_wcnt = comp ? 0 : m_wcnt + 1;
    end else m_wcnt = 0;
    if (comp && !swp) m_pend = 1;
    if (swp) begin
      m_pend = 0;
      m_wb   = 1 - m_wb;
      m_rb   = 1 - m_rb;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("outputs_a",
        int'({bus_a.lcd_data, bus_a.lcd_de, bus_a.lcd_hs, bus_a.lcd_vs,
              bus_a.lcd_frame_start, bus_a.drop_err, bus_a.overrun}),
        int'({e_data, e_de, e_hs, e_vs, e_fs, e_drop, e_ovr}));
    if (!bus_b.lcd_de) chk("b_data_blank", int'(bus_b.lcd_data), 0);
    if (bus_a.lcd_de) begin
      qa.push_back(bus_a.lcd_data);
      if (bus_a.lcd_data >= 8'hA0 && bus_a.lcd_data <= 8'hAF) saw_a++;
    end
    if (bus_a.lcd_frame_start) last_fs = cyc;
    if (bus_a.drop_err) n_drop++;
    if (bus_a.overrun) n_ovr++;
    if (bus_b.lcd_de) qb.push_back(bus_b.lcd_data);
    if (bus_b.lcd_frame_start) fsb.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_fs();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = bus_a.lcd_frame_start;
    end
    chk("frame_start_seen", int'(got), 1);
  endtask

  task automatic burst(input bit to_b, input logic [7:0] base,
                       input int len);
    for (int i = 0; i < len; i++) begin
      if (to_b) begin
        bus_b.pix_in    = base + 8'(i);
        bus_b.pix_valid = 1'b1;
      end else begin
        bus_a.pix_in    = base + 8'(i);
        bus_a.pix_valid = 1'b1;
      end
      step();
    end
    bus_a.pix_valid = 1'b0;
    bus_b.pix_valid = 1'b0;
  endtask

  function automatic int frame_err(input logic [7:0] base);
    int e = 0;
    if (qa.size() != 16) return 99;
    for (int i = 0; i < 16; i++)
      if (qa[i] !== base + 8'(i)) e++;
    return e;
  endfunction

  task automatic clr();
    n_drop = 0;
    n_ovr  = 0;
    saw_a  = 0;
  endtask

  initial begin
    int f0, fs_prev, e;
    tbl[0] = '{7,  8'h50, 1, 0, 8'h10};
    tbl[1] = '{16, 8'h20, 0, 0, 8'h20};
    tbl[2] = '{5,  8'h60, 1, 0, 8'h20};
    tbl[3] = '{16, 8'h30, 0, 0, 8'h30};
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) m_bank[b][i] = 8'd0;
    clr();
    reset           = 1'b1;
    bus_a.pix_in    = 8'd0;
    bus_a.pix_valid = 1'b0;
    bus_b.pix_in    = 8'd0;
    bus_b.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({bus_a.lcd_data, bus_a.lcd_de, bus_a.lcd_hs, bus_a.lcd_vs,
              bus_a.lcd_frame_start, bus_a.drop_err, bus_a.overrun}), 0);
    reset = 1'b0;
    model_reset();
    idle(5);

    // first frame out of IDLE
    qa.delete();
    burst(0, 8'h10, 16);
    wait_fs();
    f0 = last_fs;
    wait_fs();
    chk("t1_frame", frame_err(8'h10), 0);
    chk("t1_period", last_fs - f0, 27);

    // repeats with no new input
    clr();
    for (int k = 0; k < 3; k++) begin
      fs_prev = last_fs;
      qa.delete();
      wait_fs();
      chk("t2_period", last_fs - fs_prev, 27);
      chk("t2_frame", frame_err(8'h10), 0);
    end
    chk("t2_drop", n_drop, 0);
    chk("t2_ovr", n_ovr, 0);

    // bursts placed just after a frame start
    for (int k = 0; k < 4; k++) begin
      wait_fs();
      clr();
      burst(0, tbl[k].base, tbl[k].len);
      wait_fs();
      qa.delete();
      wait_fs();
      chk("tbl_frame", frame_err(tbl[k].show), 0);
      chk("tbl_drop", n_drop, tbl[k].drops);
      chk("tbl_ovr", n_ovr, tbl[k].ovrs);
    end

    // two bursts before one swap point: second wins
    wait_fs();
    clr();
    idle(11);
    burst(0, 8'hA0, 16);
    burst(0, 8'hB0, 16);
    wait_fs();
    wait_fs();
    qa.delete();
    wait_fs();
    chk("t4_frame", frame_err(8'hB0), 0);
    chk("t4_ovr", n_ovr, 1);
    chk("t4_never_a", saw_a, 0);
    chk("t4_drop", n_drop, 0);

    // completion exactly on the last pixel cycle: bypass
    wait_fs();
    clr();
    idle(10);
    burst(0, 8'hC0, 16);
    wait_fs();
    qa.delete();
    wait_fs();
    chk("t5_frame", frame_err(8'hC0), 0);
    chk("t5_ovr", n_ovr, 0);

    // reset in ACTIVE row 2
    wait_fs();
    idle(18);
    chk("t6_in_active", int'(bus_a.lcd_de), 1);
    reset = 1'b1;
    #1;
    chk("t6_reset_outs",
        int'({bus_a.lcd_data, bus_a.lcd_de, bus_a.lcd_hs, bus_a.lcd_vs,
              bus_a.lcd_frame_start, bus_a.drop_err, bus_a.overrun}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    qa.delete();
    idle(30);
    burst(0, 8'hD0, 6);
    idle(40);
    chk("t6_stays_idle", qa.size(), 0);
    burst(0, 8'hE0, 16);
    wait_fs();
    qa.delete();
    wait_fs();
    chk("t6_restart", frame_err(8'hE0), 0);

    // V_BLANK=1, H_BLANK=1, PIX_DIV=2 instance
    qb.delete();
    fsb.delete();
    burst(1, 8'h70, 16);
    idle(120);
    chk("t7_fs_count_ok", int'(fsb.size() >= 3), 1);
    if (fsb.size() >= 3) begin
      chk("t7_period0", fsb[1] - fsb[0], 37);
      chk("t7_period1", fsb[2] - fsb[1], 37);
    end
    chk("t7_de_count_ok", int'(qb.size() >= 64), 1);
    if (qb.size() >= 64) begin
      e = 0;
      for (int i = 0; i < 16; i++) begin
        if (qb[2 * i] !== 8'h70 + 8'(i)) e++;
        if (qb[2 * i + 1] !== 8'h70 + 8'(i)) e++;
        if (qb[32 + 2 * i] !== 8'h70 + 8'(i)) e++;
      end
      chk("t7_hold2", e, 0);
    end

    // random bursts, back-to-back runs and aborts
    for (int n = 0; n < 60; n++) begin
      int sel, len;
      sel = $urandom_range(0, 3);
      len = (sel == 0) ? $urandom_range(1, 20) :
            (sel == 1) ? 32 : 16;
      for (int i = 0; i < len; i++) begin
        bus_a.pix_in    = 8'($urandom);
        bus_a.pix_valid = 1'b1;
        step();
      end
      bus_a.pix_valid = 1'b0;
      idle($urandom_range(0, 40));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
